// File: rtl/adder_tree_accum_pkg.sv
// adder_tree_accum_pkg: shared types and constant helpers for the adder tree accumulator
package adder_tree_accum_pkg;
  typedef enum logic {START, ACCUM} acc_state_e;
  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) ;
    return r;
  endfunction
  // Bit offset of tree level s inside the flattened all-levels bus
  function automatic int lvl_off(input int nch, input int w, input int s);
    return w * (2 * nch - 2 * (nch >> s));
  endfunction
endpackage

// File: rtl/adder_tree_stage.sv
// adder_tree_stage: one registered level of pairwise adders with a travelling valid bit
module adder_tree_stage #(
  parameter int N = 2,
  parameter int W = 8
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iEN,
  input  logic             ivalid,
  input  logic [N*W-1:0]   idata,
  output logic             ovalid,
  output logic [N/2*W-1:0] odata
);
  logic [N/2*W-1:0] sum;
  for (genvar i = 0; i < N / 2; i++) begin : g_add
    assign sum[i*W +: W] = idata[2*i*W +: W] + idata[(2*i+1)*W +: W];
  end
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) begin
      odata  <= '0;
      ovalid <= 1'b0;
    end else if (iEN) begin
      odata  <= sum;
      ovalid <= ivalid;
    end
endmodule

// File: rtl/adder_tree_accum.sv
// adder_tree_accum: registered NCH-channel adder tree followed by a programmable-length accumulator
module adder_tree_accum
  import adder_tree_accum_pkg::*;
#(
  parameter int WL     = 4,
  parameter int NCH    = 8,
  parameter int SIGNED = 0,
  parameter int ACCW   = 4,
  localparam int LOGN  = clog2(NCH),
  localparam int OWL   = WL + LOGN + ACCW
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iEN,
  input  logic              iVALID,
  input  logic [NCH*WL-1:0] idata,
  input  logic [ACCW-1:0]   iACC_LEN,
  input  logic              iCLR,
  output logic              oVALID,
  output logic [OWL-1:0]    odata
);
  localparam int TW = OWL * (2 * NCH - 1);
  logic [NCH*OWL-1:0] ext, x_q;
  logic               x_v;
  logic [TW-1:0]      tree;
  logic [LOGN:0]      tv;
  logic [OWL-1:0]     s, acc;
  logic               v;
  logic [ACCW-1:0]    cnt, len_q;
  acc_state_e         st;
  for (genvar k = 0; k < NCH; k++) begin : g_ext
    logic [WL-1:0] c;
    assign c = idata[k*WL +: WL];
    assign ext[k*OWL +: OWL] = {{(OWL-WL){SIGNED != 0 && c[WL-1]}}, c};
  end
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) begin
      x_q <= '0;
      x_v <= 1'b0;
    end else if (iEN) begin
      x_q <= ext;
      x_v <= iVALID;
    end
  // All levels share one flat bus: level 0 is the input register, level LOGN the final sum
  assign tree[NCH*OWL-1:0] = x_q;
  assign tv[0] = x_v;
  for (genvar l = 0; l < LOGN; l++) begin : g_lvl
    adder_tree_stage #(.N(NCH >> l), .W(OWL)) u_stage (
      .iCLK  (iCLK),
      .iRST  (iRST),
      .iEN   (iEN),
      .ivalid(tv[l]),
      .idata (tree[lvl_off(NCH, OWL, l) +: (NCH >> l) * OWL]),
      .ovalid(tv[l+1]),
      .odata (tree[lvl_off(NCH, OWL, l + 1) +: (NCH >> (l + 1)) * OWL])
    );
  end
  assign s  = tree[TW-1 -: OWL];
  assign v  = tv[LOGN];
  assign st = (cnt == '0) ? START : ACCUM;
  // Clear outranks the enable and drops any tree result arriving in the same cycle
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) begin
      acc    <= '0;
      cnt    <= '0;
      len_q  <= '0;
      odata  <= '0;
      oVALID <= 1'b0;
    end else if (iCLR) begin
      acc    <= '0;
      cnt    <= '0;
      oVALID <= 1'b0;
    end else if (iEN) begin
      oVALID <= 1'b0;
      if (v && st == START) begin
        len_q <= iACC_LEN;
        if (iACC_LEN == '0) begin
          odata  <= s;
          oVALID <= 1'b1;
        end else begin
          acc <= s;
          cnt <= 1;
        end
      end else if (v) begin
        if (cnt == len_q) begin
          odata  <= acc + s;
          oVALID <= 1'b1;
          cnt    <= '0;
        end else begin
          acc <= acc + s;
          cnt <= cnt + 1'b1;
        end
      end
    end
endmodule
